// File: rtl/uart_ram_cmd.sv
// Host command decoder: parses 'W' addr data / 'R' addr byte streams from the UART,
// drives the 16x8 single-port RAM and returns exactly one reply byte per command.
module uart_ram_cmd #(
    parameter int unsigned TIMEOUT_CYCLES = 27000000,
    parameter logic [7:0]  OP_WRITE       = 8'h57,
    parameter logic [7:0]  OP_READ        = 8'h52
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_send_n,
    output logic [3:0] ram_ad,
    output logic [7:0] ram_di,
    output logic       ram_wre,
    input  logic [7:0] ram_dout,
    output logic       busy,
    output logic [7:0] drop_cnt
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_WRITE, S_RD_ADDR,
        S_RD_WAIT, S_RD_CAP, S_SEND, S_TX_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic             wr_q, wr_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       reply_q, reply_d;
    logic [7:0]       txd_q, txd_d;
    logic [7:0]       drop_q, drop_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            reply_q <= '0;
            txd_q   <= '0;
            drop_q  <= '0;
            tmo_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            reply_q <= reply_d;
            txd_q   <= txd_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        reply_d = reply_q;
        txd_d   = txd_q;
        drop_d  = drop_q;
        tmo_d   = '0;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WRITE) begin
                        wr_d    = 1'b1;
                        state_d = S_GET_ADDR;
                    end else if (rx_data == OP_READ) begin
                        wr_d    = 1'b0;
                        state_d = S_GET_ADDR;
                    end else begin
                        reply_d = 8'h3F;
                        state_d = S_SEND;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    if (rx_data[7:4] != 4'h0) begin
                        reply_d = 8'h21;
                        state_d = S_SEND;
                    end else begin
                        addr_d  = rx_data[3:0];
                        state_d = wr_q ? S_GET_DATA : S_RD_ADDR;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_GET_DATA: begin
                // A byte arriving in the expiry cycle still completes the command.
                if (rx_valid) begin
                    wdata_d = rx_data;
                    state_d = S_WRITE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WRITE: begin
                reply_d = 8'h4B;
                state_d = S_SEND;
            end
            S_RD_ADDR: state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_RD_CAP;
            S_RD_CAP: begin
                reply_d = ram_dout;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    txd_d   = reply_q;
                    hold_d  = 1'b0;
                    state_d = S_TX_HOLD;
                end
            end
            S_TX_HOLD: begin
                // Give the UART two cycles to drop tx_ready before trusting it again.
                if (hold_q) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rx_valid && drop_q != 8'hFF &&
            (state_q inside {S_WRITE, S_RD_ADDR, S_RD_WAIT, S_RD_CAP, S_SEND, S_TX_HOLD})) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        ram_wre   = (state_q == S_WRITE);
        tx_send_n = !((state_q == S_SEND) && tx_ready);
        tx_data   = ((state_q == S_SEND) && tx_ready) ? reply_q : txd_q;
        ram_ad    = addr_q;
        ram_di    = wdata_q;
        drop_cnt  = drop_q;
    end
endmodule

// File: doc/uart_ram_cmd.md
Name: uart_ram_cmd

Overview:
- Command decoder between the UART receive/transmit path and the 16x8 single-port block RAM (Gowin_RAM16S).
- Consumes received bytes and parses a 2- or 3-byte command protocol.
- Performs RAM reads and writes, then hands one reply byte per command to the UART transmitter.
- Replaces the fixed 1 s polling loop in the top level with an event-driven, host-controlled memory port.

Parameters:
- TIMEOUT_CYCLES, 27000000: idle cycles allowed between bytes of one command before the partial command is dropped (1 s at 27 MHz).
- OP_WRITE, 8'h57: opcode 'W'.
- OP_READ, 8'h52: opcode 'R'.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst_n  input  1  synchronous, active-low reset.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- tx_ready  input  1  high when the UART transmitter is idle and can accept a byte.
- tx_data  output  8  reply byte; held stable from the send strobe until the next send.
- tx_send_n  output  1  active-low, one-cycle send strobe to the UART.
- ram_ad  output  4  RAM address.
- ram_di  output  8  RAM write data.
- ram_wre  output  1  RAM write enable; one cycle per write.
- ram_dout  input  8  RAM read data; valid the cycle after the RAM samples ram_ad with ram_wre=0.
- busy  output  1  high whenever the state is not IDLE.
- drop_cnt  output  8  saturating count of rx bytes discarded while busy in non-receive states.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces state IDLE and sets tx_send_n=1, ram_wre=0, ram_ad=0, ram_di=0, tx_data=0, busy=0, drop_cnt=0, and clears the timeout counter.
- Reset mid-command aborts the command: no write, no reply.
- States: IDLE, GET_ADDR, GET_DATA, WRITE, RD_ADDR, RD_WAIT, RD_CAP, SEND, TX_HOLD.
- IDLE, on rx_valid:
  - OP_WRITE -> GET_ADDR with the write flag set.
  - OP_READ -> GET_ADDR with the write flag cleared.
  - Any other byte -> SEND with reply 8'h3F ('?').
- GET_ADDR, on rx_valid:
  - If rx_data[7:4] != 0, go to SEND with reply 8'h21 ('!'); no RAM access.
  - Otherwise latch rx_data[3:0], then go to GET_DATA (write) or RD_ADDR (read).
- GET_DATA, on rx_valid: latch the data byte and go to WRITE.
- WRITE: drive ram_wre=1 with ram_ad and ram_di for exactly one cycle, then go to SEND with reply 8'h4B ('K').
- RD_ADDR: drive ram_ad with ram_wre=0.
- RD_WAIT: wait one cycle.
- RD_CAP: capture ram_dout as the reply, then go to SEND.
- SEND: stay until tx_ready=1. In that cycle drive tx_data and tx_send_n=0 for one cycle, then go to TX_HOLD.
- TX_HOLD: ignore tx_ready for 2 cycles (UART deassert latency), then go to IDLE.
- Timeout:
  - In GET_ADDR and GET_DATA a counter increments each cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT_CYCLES, return to IDLE silently with no reply and no write.
  - rx_valid in the same cycle as expiry wins: the byte is accepted and the timeout is ignored.
- Drops: rx_valid in WRITE, RD_*, SEND or TX_HOLD discards the byte and increments drop_cnt, which saturates at 8'hFF (no wrap).
- Latency, measured from the rx_valid cycle of the last command byte and assuming tx_ready=1:
  - Write: ram_wre high at +1; tx_send_n low at +2.
  - Read: ram_ad valid at +1; reply captured at +3; tx_send_n low at +4.
  - Error replies: tx_send_n low at +1.
- ram_wre is never high outside WRITE.
- tx_send_n is never low for more than one consecutive cycle.
- Exactly one reply is sent per completed or rejected command.

Test Plan:
- Write then read: bytes 57,03,A5 -> one-cycle ram_wre, ad=3, di=A5, reply 4B. Then bytes 52,03 -> reply A5 exactly 4 cycles after the address byte.
- Unknown opcode: byte 41 -> reply 3F; no ram_wre; busy returns low after TX_HOLD.
- Bad address: bytes 57,13 -> reply 21; no write. The following 52,03 still returns the previously written value.
- Timeout: byte 57, then silence for TIMEOUT_CYCLES (set to 100 in the bench) -> back to IDLE with no tx_send_n. A subsequent 52,00 works normally.
- Backpressure and drops: hold tx_ready=0 after 52,00. Send 3 extra bytes -> drop_cnt=3, tx_send_n stays 1. Raise tx_ready -> one strobe with correct data.
- Reset mid-command: after 57,05, pulse rst_n=0 for 1 cycle, then send A5 -> treated as an opcode (reply 3F). Location 5 is unchanged and all outputs are at reset values during reset.
